// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared fetch-stage types: default widths and constants, FSM encoding, IF/ID and skid record layouts.
package fetch_stage_ctrl_pkg;

  localparam int DEF_XLEN = 32;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                valid;
    logic [DEF_XLEN-1:0] pc;
    logic [31:0]         instr;
  } ifid_t;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch response that arrives while decode is stalled.
module fetch_skid_buf
  import fetch_stage_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t entry,
  output fetch_entry_t held,
  output logic         valid
);

  // Clear wins over load so a flush in the same cycle leaves the buffer empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      held  <= entry;
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch controller: PC, single-outstanding imem requests, IF/ID register with stall/flush handling.
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inflight_q, inflight_d;
  logic             drop_q, drop_d;
  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q;

  logic             skid_load, skid_clear, skid_valid;
  fetch_entry_t     skid_entry, skid_held;

  assign skid_entry = '{pc: inflight_q, instr: imem_rdata};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .entry (skid_entry),
    .held  (skid_held),
    .valid (skid_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= 1'b0;
      ifid_q     <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ifid_q     <= ifid_d;
      if (stall_req && !flush_req && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    ifid_d     = stall_req ? ifid_q : '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};

    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          inflight_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall_req) begin
            ifid_d  = '{valid: 1'b1, pc: inflight_q, instr: imem_rdata};
            state_d = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_req) begin
          if (skid_valid)
            ifid_d = '{valid: 1'b1, pc: skid_held.pc, instr: skid_held.instr};
          skid_clear = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect overrides everything; a request already granted becomes wrong-path and is dropped.
    if (flush_req) begin
      pc_d       = redirect_pc;
      ifid_d     = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
      skid_load  = 1'b0;
      skid_clear = 1'b1;
      drop_d     = 1'b0;
      state_d    = S_REQ;
      if (state_q == S_WAIT && !imem_rvalid) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else if (state_q == S_REQ && imem_gnt) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end
    end
  end

  always_comb begin
    imem_req    = (state_q == S_REQ) && !rst;
    idex_bubble = (stall_req & ~flush_req) | flush_req;
  end

  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_instr  = ifid_q.instr;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl with a queue-based reference model checked every cycle.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_req = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        idex_bubble;
  logic [15:0] stall_count;

  fetch_stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifid_valid  (ifid_valid),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .idex_bubble (idex_bubble),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding fetches plus a parked response.
  typedef struct {
    logic [31:0] pc;
    bit          dead;
  } fetch_t;

  fetch_t      pend[$];
  fetch_t      popped;
  bit          held_v;
  logic [31:0] held_pc, held_instr;
  bit          m_v, n_v;
  logic [31:0] m_ifpc, m_ifinstr, n_ifpc, n_ifinstr;
  logic [31:0] m_pc;
  int unsigned m_cnt;
  bit          m_init = 1'b0;
  bit          m_issue;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; pend.delete(); held_v = 0;
      m_v = 0; m_ifpc = 32'h0; m_ifinstr = NOP; m_cnt = 0; m_init = 1;
    end else begin
      m_issue = (pend.size() == 0) && !held_v;
      if (stall_req) begin
        n_v = m_v; n_ifpc = m_ifpc; n_ifinstr = m_ifinstr;
      end else begin
        n_v = 0; n_ifpc = m_ifpc; n_ifinstr = NOP;
      end
      if (held_v && !stall_req) begin
        n_v = 1; n_ifpc = held_pc; n_ifinstr = held_instr; held_v = 0;
      end
      if (pend.size() > 0 && imem_rvalid) begin
        popped = pend.pop_front();
        if (!popped.dead && !flush_req) begin
          if (stall_req) begin
            held_v = 1; held_pc = popped.pc; held_instr = imem_rdata;
          end else begin
            n_v = 1; n_ifpc = popped.pc; n_ifinstr = imem_rdata;
          end
        end
      end
      if (m_issue && imem_gnt) begin
        pend.push_back('{pc: m_pc, dead: flush_req});
        m_pc = m_pc + 32'd4;
      end
      if (flush_req) begin
        m_pc = redirect_pc; held_v = 0;
        n_v = 0; n_ifpc = m_ifpc; n_ifinstr = NOP;
        foreach (pend[i]) pend[i].dead = 1;
      end
      if (stall_req && !flush_req && m_cnt != 32'd65535) m_cnt++;
      m_v = n_v; m_ifpc = n_ifpc; m_ifinstr = n_ifinstr;
    end
  end

  bit exp_req;
  always @(negedge clk) begin
    if (m_init) begin
      exp_req = !rst && (pend.size() == 0) && !held_v;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
      chk("ifid_pc", ifid_pc, m_ifpc);
      chk("ifid_instr", ifid_instr, m_ifinstr);
      chk("idex_bubble", 32'(idex_bubble), 32'(stall_req | flush_req));
      chk("stall_count", 32'(stall_count), m_cnt);
    end
  end

  logic s_req, s_bub;

  task automatic cyc(input logic r, input logic s, input logic f, input logic [31:0] rpc,
                     input logic g, input logic v, input logic [31:0] d);
    rst = r; stall_req = s; flush_req = f; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    @(negedge clk);
    s_req = imem_req;
    s_bub = idex_bubble;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 1, 32'hC0DE_0000 + 32'(i));
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("req_in_reset", 32'(s_req), 32'h0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("req_in_reset2", 32'(s_req), 32'h0);
    chk("rst_ifid_valid", 32'(ifid_valid), 32'h0);
    chk("rst_ifid_instr", ifid_instr, NOP);
    chk("rst_count", 32'(stall_count), 32'h0);

    // Free run, immediate grant, k=1
    run(2);
    chk("fr_pc0", ifid_pc, 32'h0);
    chk("fr_v0", 32'(ifid_valid), 32'h1);
    chk("fr_instr0", ifid_instr, 32'hC0DE_0001);
    run(1);
    chk("fr_bubble", 32'(ifid_valid), 32'h0);
    run(1);
    chk("fr_pc4", ifid_pc, 32'h4);
    run(2);
    chk("fr_pc8", ifid_pc, 32'h8);

    // Stall while waiting: response parks in the skid
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("st_addr_granted", imem_addr, 32'h10);
    cyc(0, 1, 0, 0, 0, 1, 32'h1111_AAAA);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("st_req_hold", 32'(imem_req), 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("st_ifid_pc_held", ifid_pc, 32'h8);
    chk("st_ifid_v_held", 32'(ifid_valid), 32'h0);
    chk("st_count3", 32'(stall_count), 32'd3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("st_rel_v", 32'(ifid_valid), 32'h1);
    chk("st_rel_pc", ifid_pc, 32'hC);
    chk("st_rel_instr", ifid_instr, 32'h1111_AAAA);

    // Flush while waiting; late response is wrong-path
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 32'h100, 0, 0, 0);
    chk("fl_bub", 32'(s_bub), 32'h1);
    chk("fl_v", 32'(ifid_valid), 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("fl_instr", ifid_instr, NOP);
    chk("fl_req", 32'(imem_req), 32'h1);
    chk("fl_addr", imem_addr, 32'h100);

    // Flush + stall + grant together
    cyc(0, 1, 1, 32'h200, 1, 0, 0);
    chk("fsg_bub", 32'(s_bub), 32'h1);
    chk("fsg_count", 32'(stall_count), 32'd3);
    chk("fsg_req", 32'(imem_req), 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'hBAD0_0001);
    chk("fsg_drop", 32'(ifid_valid), 32'h0);
    chk("fsg_addr", imem_addr, 32'h200);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0040_0513);
    chk("fsg_pc", ifid_pc, 32'h200);
    chk("fsg_instr", ifid_instr, 32'h0040_0513);

    // PC wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wr_wrap", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h00A0_0093);
    chk("wr_ifid_pc", ifid_pc, 32'hFFFF_FFFC);

    // Reset mid-fetch; the late response is ignored
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rm_req", 32'(s_req), 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("rm_instr", ifid_instr, NOP);
    chk("rm_v", 32'(ifid_valid), 32'h0);
    chk("rm_addr", imem_addr, 32'h0);
    chk("rm_req2", 32'(imem_req), 32'h1);
    run(4);

    // Counter saturation
    for (int i = 0; i < 65536 + 5; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      if (i == 65533) chk("sat_fffe", 32'(stall_count), 32'h0000_FFFE);
    end
    chk("sat_ffff", 32'(stall_count), 32'h0000_FFFF);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
Fetch-side pipeline controller for the RV32I core. It owns the PC register and the IF/ID pipeline register. It sits on the receiving end of the hazard-detection stall request and the EX-stage redirect (flush), issues single-outstanding requests to instruction memory, and holds, refills or bubbles IF/ID in response. It also generates the ID/EX bubble select and a stall performance counter.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding placed in IF/ID when invalid (addi x0,x0,0)
CNT_W, 16, width of stall_count (saturating)

Ports:
clk  in  1  core clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
stall_req  in  1  load-use stall from hazard detection; hold PC and IF/ID this cycle
flush_req  in  1  taken branch/jump resolved in EX
redirect_pc  in  XLEN  target PC, valid with flush_req
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, equals pc while imem_req=1
imem_gnt  in  1  memory accepts request this cycle (only meaningful when imem_req=1)
imem_rvalid  in  1  response valid, earliest 1 cycle after grant
imem_rdata  in  32  fetched instruction
ifid_valid  out  1  IF/ID holds a live instruction
ifid_pc  out  XLEN  PC of the IF/ID instruction
ifid_instr  out  32  IF/ID instruction (NOP_INSTR when ifid_valid=0)
idex_bubble  out  1  select NOP control into ID/EX (combinational)
stall_count  out  CNT_W  number of cycles with stall_req=1 and flush_req=0, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; state=S_REQ; drop=0; skid empty.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, stall_count=0.
  - imem_req=0 while rst=1.
  - Reset mid-fetch abandons the request. Any imem_rvalid arriving while state=S_REQ is ignored.
- States:
  - S_REQ: imem_req=1, imem_addr=pc. On imem_gnt: inflight_pc<=pc, pc<=pc+4 (mod 2^XLEN, wraps), go to S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid:
    - drop=1: discard the response, drop<=0, go to S_REQ.
    - stall_req=0: IF/ID<= {1, inflight_pc, imem_rdata}, go to S_REQ.
    - stall_req=1: skid<= {inflight_pc, imem_rdata}, go to S_HOLD.
  - S_HOLD: imem_req=0. When stall_req=0: IF/ID<=skid, go to S_REQ.
- IF/ID update rule when not otherwise loaded:
  - stall_req=1: IF/ID holds its value.
  - stall_req=0: IF/ID<= {0, ifid_pc, NOP_INSTR} (bubble).
- Flush (priority over stall and over every state action):
  - pc<=redirect_pc; IF/ID invalidated to NOP; skid cleared; next state=S_REQ.
  - If state=S_WAIT without rvalid this cycle: drop<=1 and stay in S_WAIT.
  - If state=S_REQ with imem_gnt this cycle: the granted wrong-path request gets drop<=1, go to S_WAIT, and pc<=redirect_pc (no +4).
  - If rvalid arrives in the same cycle as the flush: the response is discarded.
- idex_bubble = (stall_req & ~flush_req) | flush_req. The flushed ID instruction must not reach EX.
- stall_count increments when stall_req=1 and flush_req=0. It holds at all-ones.
- Latency: grant at cycle N, rvalid at N+k (k≥1), ifid_valid=1 from N+k+1. The next request is issued in the cycle after the response is captured. Peak throughput is 1 instr / 2 cycles with k=1.
- Invariant: at most one outstanding request. imem_req is never asserted in S_WAIT or S_HOLD.

Decomposition:
- Shared core package holds:
  - XLEN, NOP_INSTR, RESET_PC defaults.
  - State encoding S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2.
  - IF/ID record layout {valid, pc, instr}.
- One natural sub-module: fetch_skid_buf, a one-entry holding register with load/clear/valid.
- FSM, PC and counter stay in the top module.

Test Plan:
- Reset then free-run with grant immediate and k=1 -> ifid_pc sequence 0x0, 0x4, 0x8 with ifid_valid high every other cycle from cycle 3; imem_req=0 during reset.
- stall_req=1 for 3 cycles while in S_WAIT and rvalid arrives -> S_HOLD entered; IF/ID unchanged for 3 cycles; skid contents appear in IF/ID the cycle after stall drops; stall_count=3.
- flush_req with redirect_pc=0x100 while S_WAIT, rvalid one cycle later with 0xDEADBEEF -> 0xDEADBEEF never appears in IF/ID; next imem_addr=0x100; ifid_valid=0 and idex_bubble=1 in the flush cycle.
- flush_req and stall_req together, and flush together with imem_gnt in S_REQ -> flush wins; the granted response is dropped; pc=redirect_pc rather than redirect_pc+4; stall_count unchanged.
- pc=0xFFFF_FFFC granted -> pc wraps to 0x0; rst asserted while in S_WAIT, then rvalid -> response ignored, ifid_instr=0x0000_0013, fetch restarts at RESET_PC.
- Hold stall_req high for 2^CNT_W+5 cycles -> stall_count saturates at 0xFFFF.
